// File: rtl/pll_mode_reconfig_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_mode_reconfig_if
// Description : Avalon-MM reconfiguration bus between the mode sequencer
//               and the PLL reconfig IP.
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_mode_reconfig_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_read;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic [31:0] mgmt_readdata;

  modport master (
    output mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
    input  mgmt_waitrequest, mgmt_readdata
  );

  modport slave (
    input  mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
    output mgmt_waitrequest, mgmt_readdata
  );
endinterface
`default_nettype wire

// File: rtl/pll_mode_reconfig.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_mode_reconfig
// Description : Retunes the system PLL between PAL and NTSC clocking through
//               its reconfig port, then waits for lock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_mode_reconfig #(
  parameter bit          INIT_PAL = 1'b1,
  parameter logic [31:0] M_PAL    = 32'h00000404,
  parameter logic [31:0] M_NTSC   = 32'h00000404,
  parameter logic [31:0] K_PAL    = 32'h3C6A7EF9,
  parameter logic [31:0] K_NTSC   = 32'hE147AE14,
  parameter logic [23:0] TIMEOUT  = 24'd5000000
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           pal,
  input  wire logic           pll_locked,
  pll_mode_reconfig_if.master mgmt,
  output logic                busy,
  output logic                cfg_pal,
  output logic                err
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_MODE   = 3'd1,
    ST_WR_M      = 3'd2,
    ST_WR_K      = 3'd3,
    ST_WR_START  = 3'd4,
    ST_RD_STATUS = 3'd5,
    ST_RD_GAP    = 3'd6,
    ST_WAIT_LOCK = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_target;
  logic        r_cfg_pal;
  logic        r_err;
  logic [23:0] r_tmo_cnt;
  logic        r_lock_meta;
  logic        r_lock_sync;

  logic [5:0]  w_address;
  logic        w_read;
  logic        w_write;
  logic [31:0] w_writedata;
  logic        w_xfer_ok;
  logic        w_timed;
  logic        w_timeout;
  logic        w_start;
  logic        w_unused_rdata;

  assign w_xfer_ok      = ~mgmt.mgmt_waitrequest;
  assign w_timed        = (r_state == ST_RD_STATUS) || (r_state == ST_RD_GAP) ||
                          (r_state == ST_WAIT_LOCK);
  assign w_timeout      = w_timed && (r_tmo_cnt == (TIMEOUT - 24'd1));
  assign w_start        = (r_state == ST_IDLE) && (pal != r_cfg_pal);
  assign w_unused_rdata = ^mgmt.mgmt_readdata[31:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bus strobes are decoded from state so they stay put while waitrequest holds.
  always_comb begin
    w_next_state = r_state;
    w_address    = 6'd0;
    w_read       = 1'b0;
    w_write      = 1'b0;
    w_writedata  = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next_state = ST_WR_MODE;
      end
      ST_WR_MODE: begin
        w_write     = 1'b1;
        w_address   = 6'd0;
        w_writedata = 32'd1;
        if (w_xfer_ok) w_next_state = ST_WR_M;
      end
      ST_WR_M: begin
        w_write     = 1'b1;
        w_address   = 6'd4;
        w_writedata = r_target ? M_PAL : M_NTSC;
        if (w_xfer_ok) w_next_state = ST_WR_K;
      end
      ST_WR_K: begin
        w_write     = 1'b1;
        w_address   = 6'd7;
        w_writedata = r_target ? K_PAL : K_NTSC;
        if (w_xfer_ok) w_next_state = ST_WR_START;
      end
      ST_WR_START: begin
        w_write     = 1'b1;
        w_address   = 6'd2;
        w_writedata = 32'd1;
        if (w_xfer_ok) w_next_state = ST_RD_STATUS;
      end
      ST_RD_STATUS: begin
        w_read    = 1'b1;
        w_address = 6'd1;
        if (w_xfer_ok) begin
          w_next_state = mgmt.mgmt_readdata[0] ? ST_WAIT_LOCK : ST_RD_GAP;
        end
      end
      ST_RD_GAP: begin
        w_next_state = ST_RD_STATUS;
      end
      ST_WAIT_LOCK: begin
        if (r_lock_sync) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (w_timeout) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target    <= INIT_PAL;
      r_cfg_pal   <= INIT_PAL;
      r_err       <= 1'b0;
      r_tmo_cnt   <= 24'd0;
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_sync <= r_lock_meta;

      if (w_start) begin
        r_target <= pal;
        r_err    <= 1'b0;
      end

      if (r_state == ST_WR_START) begin
        r_tmo_cnt <= 24'd0;
      end else if (w_timed) begin
        r_tmo_cnt <= r_tmo_cnt + 24'd1;
      end

      // A timeout abandons the attempt and leaves the applied mode untouched.
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if ((r_state == ST_WAIT_LOCK) && r_lock_sync) begin
        r_cfg_pal <= r_target;
      end
    end
  end

  assign mgmt.mgmt_address   = w_address;
  assign mgmt.mgmt_read      = w_read;
  assign mgmt.mgmt_write     = w_write;
  assign mgmt.mgmt_writedata = w_writedata;

  assign busy    = (r_state != ST_IDLE);
  assign cfg_pal = r_cfg_pal;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pll_mode_reconfig.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pll_mode_reconfig
// Description : Directed self-checking bench for pll_mode_reconfig.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_mode_reconfig;

  localparam logic [31:0] M_PAL  = 32'h00000404;
  localparam logic [31:0] M_NTSC = 32'h00000404;
  localparam logic [31:0] K_PAL  = 32'h3C6A7EF9;
  localparam logic [31:0] K_NTSC = 32'hE147AE14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pal   = 1'b1;
  logic lock  = 1'b1;
  logic pal2  = 1'b1;
  logic lock2 = 1'b0;
  logic busy, cfg_pal, err;
  logic busy2, cfg2, err2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wcnt = 0;
  int wait_n = 0;
  int reads_done = 0;
  int reads_base = 0;
  int status_zeros = 0;

  typedef struct {
    logic        rd;
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } xfer_t;
  xfer_t log_q[$];

  logic        hold_valid = 1'b0;
  logic [39:0] held = 40'd0;
  logic        w_status;

  always #5 clk = ~clk;

  pll_mode_reconfig_if bus ();
  pll_mode_reconfig_if bus2 ();

  pll_mode_reconfig dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pal        (pal),
    .pll_locked (lock),
    .mgmt       (bus),
    .busy       (busy),
    .cfg_pal    (cfg_pal),
    .err        (err)
  );

  pll_mode_reconfig #(.TIMEOUT(24'd100)) dut_to (
    .clk        (clk),
    .rst_n      (rst_n),
    .pal        (pal2),
    .pll_locked (lock2),
    .mgmt       (bus2),
    .busy       (busy2),
    .cfg_pal    (cfg2),
    .err        (err2)
  );

  // Slave model: each transfer is held off for wait_n cycles; status bit 0
  // reads 0 for the first status_zeros reads after reads_base.
  assign bus.mgmt_waitrequest = (bus.mgmt_read | bus.mgmt_write) && (wcnt < wait_n);
  assign w_status             = ((reads_done - reads_base) >= status_zeros);
  assign bus.mgmt_readdata    = 32'hDEADBEE0 | {31'd0, w_status};
  assign bus2.mgmt_waitrequest = 1'b0;
  assign bus2.mgmt_readdata    = 32'h00000001;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mgmt_read | bus.mgmt_write) begin
      if (bus.mgmt_waitrequest) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (bus.mgmt_read && !bus.mgmt_waitrequest) reads_done <= reads_done + 1;
    end
  end

  // Bus monitor: exclusivity, hold stability while waiting, completion log.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mgmt_read | bus.mgmt_write) begin
        n_cmp++;
        if (bus.mgmt_read && bus.mgmt_write) begin
          n_err++;
          $display("FAIL rd_wr_exclusive: read=1 write=1 at cycle %0d, required not both", cyc);
        end
      end
      if (hold_valid) begin
        n_cmp++;
        if ({bus.mgmt_read, bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata} !== held) begin
          n_err++;
          $display("FAIL hold_stable: got %h required %h at cycle %0d",
                   {bus.mgmt_read, bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata}, held, cyc);
        end
      end
      hold_valid = (bus.mgmt_read | bus.mgmt_write) && bus.mgmt_waitrequest;
      held = {bus.mgmt_read, bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata};
      if ((bus.mgmt_read | bus.mgmt_write) && !bus.mgmt_waitrequest) begin
        log_q.push_back('{bus.mgmt_read, bus.mgmt_address,
                          bus.mgmt_read ? bus.mgmt_readdata : bus.mgmt_writedata, cyc});
      end
    end else begin
      hold_valid = 1'b0;
    end
  end

  task automatic wait_cfg(input logic exp, output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (cfg_pal !== exp && busy !== 1'b1) busy_low++;
    end while (cfg_pal !== exp && n < 2000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pal = 1'b1; lock = 1'b1; pal2 = 1'b1; lock2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, cfg_pal, err} !== 3'b010) begin
      n_err++; $display("FAIL reset_status: got %b required 010", {busy, cfg_pal, err});
    end
    n_cmp++;
    if ({bus.mgmt_read, bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata} !== 40'd0) begin
      n_err++; $display("FAIL reset_bus: got %h required 0",
                        {bus.mgmt_read, bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata});
    end
    n_cmp++;
    if ({busy2, cfg2, err2} !== 3'b010) begin
      n_err++; $display("FAIL reset_status_to: got %b required 010", {busy2, cfg2, err2});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    log_q.delete();
    repeat (1000) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (log_q.size() !== 0) begin
      n_err++; $display("FAIL idle_no_bus: got %0d transfers required 0", log_q.size());
    end
    n_cmp++;
    if ({busy, cfg_pal, err} !== 3'b010) begin
      n_err++; $display("FAIL idle_status: got %b required 010", {busy, cfg_pal, err});
    end
  endtask

  task automatic test_basic_ntsc();
    int n, bl;
    logic [5:0]  ea [5] = '{6'd0, 6'd4, 6'd7, 6'd2, 6'd1};
    logic [31:0] ed [5] = '{32'd1, M_NTSC, K_NTSC, 32'd1, 32'd0};
    wait_n = 0; status_zeros = 0;
    @(posedge clk); #1;
    log_q.delete();
    pal = 1'b0;
    wait_cfg(1'b0, n, bl);
    n_cmp++;
    if (n !== 7) begin n_err++; $display("FAIL basic_latency: got %0d required 7", n); end
    n_cmp++;
    if (bl !== 0) begin n_err++; $display("FAIL basic_busy: busy low %0d cycles required 0", bl); end
    n_cmp++;
    if ({busy, err} !== 2'b00) begin n_err++; $display("FAIL basic_done: busy,err %b required 00", {busy, err}); end
    n_cmp++;
    if (log_q.size() !== 5) begin n_err++; $display("FAIL basic_count: got %0d required 5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      n_cmp++;
      if (log_q[i].rd !== (i == 4) || log_q[i].addr !== ea[i] || (i < 4 && log_q[i].data !== ed[i])) begin
        n_err++;
        $display("FAIL basic_xfer%0d: got rd=%b a=%0d d=%h required rd=%b a=%0d d=%h",
                 i, log_q[i].rd, log_q[i].addr, log_q[i].data, (i == 4), ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_waitrequest();
    int n, bl;
    logic [5:0]  ea [5] = '{6'd0, 6'd4, 6'd7, 6'd2, 6'd1};
    logic [31:0] ed [5] = '{32'd1, M_PAL, K_PAL, 32'd1, 32'd0};
    wait_n = 3; status_zeros = 0;
    @(posedge clk); #1;
    log_q.delete();
    pal = 1'b1;
    wait_cfg(1'b1, n, bl);
    n_cmp++;
    if (n !== 22) begin n_err++; $display("FAIL wait_latency: got %0d required 22", n); end
    n_cmp++;
    if (bl !== 0) begin n_err++; $display("FAIL wait_busy: busy low %0d cycles required 0", bl); end
    n_cmp++;
    if (log_q.size() !== 5) begin n_err++; $display("FAIL wait_count: got %0d required 5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      n_cmp++;
      if (log_q[i].rd !== (i == 4) || log_q[i].addr !== ea[i] || (i < 4 && log_q[i].data !== ed[i])) begin
        n_err++;
        $display("FAIL wait_xfer%0d: got rd=%b a=%0d d=%h required rd=%b a=%0d d=%h",
                 i, log_q[i].rd, log_q[i].addr, log_q[i].data, (i == 4), ea[i], ed[i]);
      end
    end
    wait_n = 0;
  endtask

  task automatic test_status_poll();
    int n, bl, nrd, last_cyc;
    wait_n = 0; status_zeros = 4;
    @(posedge clk); #1;
    reads_base = reads_done;
    log_q.delete();
    pal = 1'b0;
    lock = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, cfg_pal} !== 2'b11) begin
      n_err++; $display("FAIL poll_waiting: busy,cfg %b required 11", {busy, cfg_pal});
    end
    nrd = 0; last_cyc = 0;
    foreach (log_q[i]) begin
      if (log_q[i].rd) begin
        if (nrd > 0) begin
          n_cmp++;
          if (log_q[i].cyc - last_cyc !== 2) begin
            n_err++; $display("FAIL poll_gap%0d: got %0d cycles required 2", nrd, log_q[i].cyc - last_cyc);
          end
        end
        last_cyc = log_q[i].cyc;
        nrd++;
      end
    end
    n_cmp++;
    if (nrd !== 5) begin n_err++; $display("FAIL poll_reads: got %0d required 5", nrd); end
    lock = 1'b1;
    wait_cfg(1'b0, n, bl);
    n_cmp++;
    if (n !== 3) begin n_err++; $display("FAIL poll_lock_latency: got %0d required 3", n); end
    n_cmp++;
    if (bl !== 0) begin n_err++; $display("FAIL poll_busy: busy low %0d cycles required 0", bl); end
    status_zeros = 0;
  endtask

  task automatic test_timeout();
    int n;
    @(posedge clk); #1;
    pal2 = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (err2 !== 1'b1 && n < 500);
    n_cmp++;
    if (n !== 105) begin n_err++; $display("FAIL timeout_cycles: got %0d required 105", n); end
    n_cmp++;
    if ({err2, busy2, cfg2} !== 3'b101) begin
      n_err++; $display("FAIL timeout_status: err,busy,cfg %b required 101", {err2, busy2, cfg2});
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({err2, busy2, bus2.mgmt_write, bus2.mgmt_address} !== {3'b011, 6'd0}) begin
      n_err++; $display("FAIL timeout_retry: err,busy,wr,addr %b required 011_000000",
                        {err2, busy2, bus2.mgmt_write, bus2.mgmt_address});
    end
  endtask

  task automatic test_toggle_reset();
    int n, bl;
    logic [5:0]  ea [5] = '{6'd0, 6'd4, 6'd7, 6'd2, 6'd1};
    logic [31:0] ed [5] = '{32'd1, M_NTSC, K_NTSC, 32'd1, 32'd0};
    wait_n = 0;
    @(posedge clk); #1;
    pal = 1'b1;
    @(posedge clk); #1;
    pal = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata} !== {1'b1, 6'd7, K_PAL}) begin
      n_err++; $display("FAIL toggle_target: got wr=%b a=%0d d=%h required wr=1 a=7 d=%h",
                        bus.mgmt_write, bus.mgmt_address, bus.mgmt_writedata, K_PAL);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mgmt_read, bus.mgmt_write, busy, cfg_pal, err} !== 5'b00010) begin
      n_err++; $display("FAIL midreset_out: rd,wr,busy,cfg,err %b required 00010",
                        {bus.mgmt_read, bus.mgmt_write, busy, cfg_pal, err});
    end
    repeat (3) @(posedge clk);
    #1;
    log_q.delete();
    rst_n = 1'b1;
    wait_cfg(1'b0, n, bl);
    n_cmp++;
    if (n !== 7) begin n_err++; $display("FAIL restart_latency: got %0d required 7", n); end
    n_cmp++;
    if (log_q.size() !== 5) begin n_err++; $display("FAIL restart_count: got %0d required 5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      n_cmp++;
      if (log_q[i].rd !== (i == 4) || log_q[i].addr !== ea[i] || (i < 4 && log_q[i].data !== ed[i])) begin
        n_err++;
        $display("FAIL restart_xfer%0d: got rd=%b a=%0d d=%h required rd=%b a=%0d d=%h",
                 i, log_q[i].rd, log_q[i].addr, log_q[i].data, (i == 4), ea[i], ed[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_ntsc();
    test_waitrequest();
    test_status_poll();
    test_timeout();
    test_toggle_reset();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
